// File: rtl/sseg_scan_if.sv
// Bus between the scan controller and its host/decoder side.
//   load, din[15:0], dp_in[3:0], lz_en : host -> scan controller
//   hex[3:0], dp                       : scan controller -> hex/7-seg decoder
//   an[3:0] (active-low), blank        : scan controller -> display / segment gate
// master = host side (testbench), slave = sseg_scan_ctrl.
interface sseg_if;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  hex;
  logic        dp;
  logic [3:0]  an;
  logic        blank;

  modport master (output load, din, dp_in, lz_en,
                  input  hex, dp, an, blank);
  modport slave  (input  load, din, dp_in, lz_en,
                  output hex, dp, an, blank);
endinterface

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display, feeding a hex-to-7seg decoder one digit at a time.
//   clk, rst_n : clock, async active-low reset
//   bus.load/din/dp_in : capture display word + decimal points into shadows
//   bus.lz_en  : leading-zero suppression enable, sampled at slot rollover
//   bus.hex/dp : current digit nibble and decimal point to the decoder
//   bus.an     : active-low anodes, one low at most, dead-time at slot start
//   bus.blank  : current digit suppressed (downstream forces segments off)

// Per-digit lane: flags an all-zero nibble for suppression.
module sseg_nib_lane (
  input  logic [3:0] nib,
  output logic       zero
);
  assign zero = (nib == 4'h0);
endmodule

module sseg_scan_ctrl #(
  parameter int REFRESH_CNT = 50000,
  parameter int DEAD_CNT    = 500
) (
  input  logic   clk,
  input  logic   rst_n,
  sseg_if.slave  bus
);
  localparam int NUM_DIGITS = 4;
  localparam int CW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CNT - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CNT);

  logic [NUM_DIGITS-1:0][3:0] shadow_d;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [NUM_DIGITS-1:0]      nib_zero;
  logic [NUM_DIGITS-1:0]      zero_from;   // nibbles k..3 all zero

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          roll, sup;
  logic [3:0]    hex_q;
  logic          dp_q, blank_q, blank_nxt;
  logic [3:0]    an_q, an_nxt;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
      sseg_nib_lane u_lane (.nib(shadow_d[g]), .zero(nib_zero[g]));
    end
  endgenerate

  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = nib_zero[NUM_DIGITS-1];
    for (int k = NUM_DIGITS - 2; k >= 0; k--)
      zero_from[k] = nib_zero[k] & zero_from[k+1];
  end

  // Next-state view: the anode register is computed from post-edge cnt/idx/
  // blank so an[idx] falls exactly DEAD_CNT edges after the rollover edge.
  always_comb begin
    roll      = (cnt == CNT_LAST);
    cnt_nxt   = roll ? '0 : cnt + CW'(1);
    idx_nxt   = roll ? idx + 2'd1 : idx;
    // Digit 0 is never suppressed, so an all-zero word still shows one "0".
    sup       = bus.lz_en && (idx_nxt != 2'd0) && zero_from[idx_nxt];
    blank_nxt = roll ? sup : blank_q;
    an_nxt    = '1;
    if (!(cnt_nxt < CNT_DEAD) && !blank_nxt)
      an_nxt[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_d  <= '0;
      shadow_dp <= '0;
    end else if (bus.load) begin
      shadow_d  <= bus.din;
      shadow_dp <= bus.dp_in;
    end
  end

  // Slot outputs sample the pre-edge shadows, so a load coinciding with a
  // rollover only shows up from the following slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= CNT_LAST;
      idx     <= 2'd3;
      hex_q   <= 4'h0;
      dp_q    <= 1'b0;
      blank_q <= 1'b1;
      an_q    <= 4'hF;
    end else begin
      cnt  <= cnt_nxt;
      idx  <= idx_nxt;
      an_q <= an_nxt;
      if (roll) begin
        hex_q   <= shadow_d[idx_nxt];
        blank_q <= sup;
        dp_q    <= shadow_dp[idx_nxt] & ~sup;
      end
    end
  end

  assign bus.hex   = hex_q;
  assign bus.dp    = dp_q;
  assign bus.blank = blank_q;
  assign bus.an    = an_q;
endmodule
